rv_decode_stage: RTL and testbench

- Registered, parametrised successor to the combinational control decoder; sits between fetch and execute.
- Decodes RV32I, plus optional M and Zicsr/privileged ops, into a control word.
- Buffers it in a 2-entry skid buffer with valid/ready handshakes on both sides.
- Holds issue after traps, MRET and WFI until commit logic releases it.

---
 rtl/rv_decode_stage_pkg.sv | 89 ++++++++
 rtl/rv_decode_comb.sv | 134 +++++++++++++
 rtl/rv_decode_stage.sv | 127 ++++++++++++
 tb/tb_rv_decode_stage.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_decode_stage_pkg.sv
// Shared decode types and constants for the decode stage and its combinational decoder.
package rv_decode_stage_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MDIV = 7'b0000001;

  localparam logic [31:0] EXC_ILLEGAL    = 32'd2;
  localparam logic [31:0] EXC_BREAKPOINT = 32'd3;
  localparam logic [31:0] EXC_ECALL_M    = 32'd11;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_COPY_B,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_t;

  typedef enum logic [3:0] {
    MEM_NOP, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } mem_type_t;

  typedef enum logic [1:0] {CSR_NONE, CSR_RW, CSR_RS, CSR_RC} csr_op_t;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_CSR} reg_data_t;

  typedef logic [1:0] dec_state_t;
  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_WFI  = 2'd2;

  typedef struct packed {
    alu_op_t     alu_op;
    logic        alu_from_imm;
    logic        alu_from_pc;
    logic        reg_write;
    reg_data_t   reg_data;
    mem_type_t   mem_type;
    logic        branch;
    logic        jump;
    csr_op_t     csr_op;
    logic        csr_source;
    logic        trap_req;
    logic [31:0] exc_cause;
    logic        exc_ret;
    logic        is_wfi;
    logic        is_m;
  } dec_ctrl_t;

  // Base integer ALU operation selected by funct3.
  function automatic alu_op_t base_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Multiply/divide operation selected by funct3.
  function automatic alu_op_t mdiv_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_MUL;
      3'b001:  return ALU_MULH;
      3'b010:  return ALU_MULHSU;
      3'b011:  return ALU_MULHU;
      3'b100:  return ALU_DIV;
      3'b101:  return ALU_DIVU;
      3'b110:  return ALU_REM;
      default: return ALU_REMU;
    endcase
  endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// Purely combinational instruction to control-word decoder.
module rv_decode_comb
  import rv_decode_stage_pkg::*;
#(
  parameter bit ENABLE_M   = 1'b0,
  parameter bit ENABLE_CSR = 1'b1
) (
  input  logic [31:0] instr,
  output dec_ctrl_t   ctrl_c
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [11:0] imm12;
  logic        illegal;
  logic        unused_reg_fields;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm12  = instr[31:20];
  // Register indices are consumed by the register file, not by this decoder.
  assign unused_reg_fields = ^{instr[19:15], instr[11:7]};

  // Opcode decode; illegal encodings collapse to a bare trap control word.
  always_comb begin
    ctrl_c  = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_LUI: begin
        ctrl_c.reg_write    = 1'b1;
        ctrl_c.alu_from_imm = 1'b1;
        ctrl_c.alu_op       = ALU_COPY_B;
      end
      OPC_AUIPC: begin
        ctrl_c.reg_write    = 1'b1;
        ctrl_c.alu_from_imm = 1'b1;
        ctrl_c.alu_from_pc  = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        ctrl_c.jump         = 1'b1;
        ctrl_c.reg_write    = 1'b1;
        ctrl_c.reg_data     = WB_PC4;
        ctrl_c.alu_from_imm = 1'b1;
        ctrl_c.alu_from_pc  = (opcode == OPC_JAL);
      end
      OPC_BRANCH: begin
        ctrl_c.branch = 1'b1;
        ctrl_c.alu_op = ALU_SUB;
        illegal       = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LOAD: begin
        ctrl_c.reg_write    = 1'b1;
        ctrl_c.reg_data     = WB_MEM;
        ctrl_c.alu_from_imm = 1'b1;
        case (f3)
          3'b000:  ctrl_c.mem_type = MEM_LB;
          3'b001:  ctrl_c.mem_type = MEM_LH;
          3'b010:  ctrl_c.mem_type = MEM_LW;
          3'b100:  ctrl_c.mem_type = MEM_LBU;
          3'b101:  ctrl_c.mem_type = MEM_LHU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        ctrl_c.alu_from_imm = 1'b1;
        case (f3)
          3'b000:  ctrl_c.mem_type = MEM_SB;
          3'b001:  ctrl_c.mem_type = MEM_SH;
          3'b010:  ctrl_c.mem_type = MEM_SW;
          default: illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        ctrl_c.reg_write    = 1'b1;
        ctrl_c.alu_from_imm = 1'b1;
        ctrl_c.alu_op       = base_alu(f3);
        if (f3 == 3'b001) illegal = (f7 != F7_BASE);
        if (f3 == 3'b101) begin
          if (f7 == F7_ALT) ctrl_c.alu_op = ALU_SRA;
          else illegal = (f7 != F7_BASE);
        end
      end
      OPC_OP: begin
        ctrl_c.reg_write = 1'b1;
        if (f7 == F7_BASE) begin
          ctrl_c.alu_op = base_alu(f3);
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          ctrl_c.alu_op = ALU_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          ctrl_c.alu_op = ALU_SRA;
        end else if (f7 == F7_MDIV && ENABLE_M) begin
          ctrl_c.is_m   = 1'b1;
          ctrl_c.alu_op = mdiv_alu(f3);
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_MISC_MEM: ;
      OPC_SYSTEM: begin
        if (f3 == 3'b000) begin
          case (imm12)
            12'h000: begin
              ctrl_c.trap_req  = 1'b1;
              ctrl_c.exc_cause = EXC_ECALL_M;
            end
            12'h001: begin
              ctrl_c.trap_req  = 1'b1;
              ctrl_c.exc_cause = EXC_BREAKPOINT;
            end
            12'h302: ctrl_c.exc_ret = 1'b1;
            12'h105: ctrl_c.is_wfi  = 1'b1;
            default: illegal = 1'b1;
          endcase
        end else if (f3 == 3'b100 || !ENABLE_CSR) begin
          illegal = 1'b1;
        end else begin
          ctrl_c.reg_write  = 1'b1;
          ctrl_c.reg_data   = WB_CSR;
          ctrl_c.csr_source = f3[2];
          ctrl_c.csr_op     = csr_op_t'(f3[1:0]);
        end
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      ctrl_c           = '0;
      ctrl_c.trap_req  = 1'b1;
      ctrl_c.exc_cause = EXC_ILLEGAL;
    end
  end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered decode stage: decoder feeding a 2-entry skid buffer with issue hold FSM.
module rv_decode_stage
  import rv_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter bit          ENABLE_M   = 1'b0,
  parameter bit          ENABLE_CSR = 1'b1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             dec_valid,
  input  logic             dec_ready,
  output dec_ctrl_t        dec_ctrl,
  output logic [31:0]      dec_instr,
  output logic [XLEN-1:0]  dec_pc,
  output logic [XLEN-1:0]  dec_tval,
  input  logic             flush,
  input  logic             irq_pending,
  output logic [CNT_W-1:0] dec_count
);

  typedef struct packed {
    dec_ctrl_t       ctrl;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] tval;
  } entry_t;

  dec_ctrl_t  dec_c;
  entry_t     new_entry;
  entry_t     head_q, head_n, skid_q, skid_n;
  logic       head_v_q, head_v_n, skid_v_q, skid_v_n;
  dec_state_t state_q, state_n;
  logic       in_ready_n, dec_valid_n;
  logic       in_hs, dec_hs;

  rv_decode_comb #(
    .ENABLE_M   (ENABLE_M),
    .ENABLE_CSR (ENABLE_CSR)
  ) u_decode (
    .instr  (in_instr),
    .ctrl_c (dec_c)
  );

  assign in_hs  = in_valid && in_ready;
  assign dec_hs = dec_valid && dec_ready;

  assign new_entry = '{
    ctrl:  dec_c,
    instr: in_instr,
    pc:    in_pc,
    tval:  (dec_c.trap_req && dec_c.exc_cause == EXC_ILLEGAL) ? XLEN'(in_instr) : '0
  };

  assign dec_ctrl  = head_q.ctrl;
  assign dec_instr = head_q.instr;
  assign dec_pc    = head_q.pc;
  assign dec_tval  = head_q.tval;

  // Next-state: buffer pop/push in RUN, wake from WFI, flush overrides everything.
  always_comb begin
    head_n   = head_q;
    skid_n   = skid_q;
    head_v_n = head_v_q;
    skid_v_n = skid_v_q;
    state_n  = state_q;
    if (flush) begin
      head_v_n = 1'b0;
      skid_v_n = 1'b0;
      state_n  = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (dec_hs) begin
            if (head_q.ctrl.trap_req || head_q.ctrl.exc_ret) state_n = ST_HOLD;
            else if (head_q.ctrl.is_wfi)                     state_n = ST_WFI;
            head_n   = skid_q;
            head_v_n = skid_v_q;
            skid_v_n = 1'b0;
          end
          if (in_hs) begin
            if (!head_v_n) begin
              head_n   = new_entry;
              head_v_n = 1'b1;
            end else begin
              skid_n   = new_entry;
              skid_v_n = 1'b1;
            end
          end
        end
        ST_WFI:  if (irq_pending) state_n = ST_RUN;
        default: ;
      endcase
    end
    in_ready_n  = !skid_v_n && (state_n == ST_RUN);
    dec_valid_n = head_v_n && (state_n == ST_RUN);
  end

  // State, buffer, handshake flags and handshake counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q    <= '0;
      skid_q    <= '0;
      head_v_q  <= 1'b0;
      skid_v_q  <= 1'b0;
      state_q   <= ST_RUN;
      in_ready  <= 1'b0;
      dec_valid <= 1'b0;
      dec_count <= '0;
    end else begin
      head_q    <= head_n;
      skid_q    <= skid_n;
      head_v_q  <= head_v_n;
      skid_v_q  <= skid_v_n;
      state_q   <= state_n;
      in_ready  <= in_ready_n;
      dec_valid <= dec_valid_n;
      dec_count <= dec_count + CNT_W'(dec_hs);
    end
  end

endmodule

// File: tb/tb_rv_decode_stage.sv
// Scoreboard bench for rv_decode_stage: one instance without M, one with M on shared inputs.
module tb_rv_decode_stage;
  import rv_decode_stage_pkg::*;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] tval;
    alu_op_t     alu_op;
    logic        alu_from_imm;
    logic        reg_write;
    reg_data_t   reg_data;
    mem_type_t   mem_type;
    csr_op_t     csr_op;
    logic        csr_source;
    logic        trap_req;
    logic [31:0] exc_cause;
    logic        exc_ret;
    logic        is_wfi;
    logic        is_m;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, dec_ready, flush, irq_pending;
  logic [31:0] in_instr, in_pc;

  logic        in_ready, dec_valid;
  dec_ctrl_t   dec_ctrl;
  logic [31:0] dec_instr, dec_pc, dec_tval, dec_count;

  logic        m_in_ready, m_dec_valid;
  dec_ctrl_t   m_dec_ctrl;
  logic [31:0] m_dec_instr, m_dec_pc, m_dec_tval, m_dec_count;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  rv_decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .ENABLE_CSR(1'b1), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_ctrl(dec_ctrl), .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_tval(dec_tval),
    .flush(flush), .irq_pending(irq_pending), .dec_count(dec_count)
  );

  rv_decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .ENABLE_CSR(1'b1), .CNT_W(32)) u_dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .dec_valid(m_dec_valid), .dec_ready(dec_ready),
    .dec_ctrl(m_dec_ctrl), .dec_instr(m_dec_instr), .dec_pc(m_dec_pc), .dec_tval(m_dec_tval),
    .flush(flush), .irq_pending(irq_pending), .dec_count(m_dec_count)
  );

  function automatic exp_t act_of(input dec_ctrl_t c, input logic [31:0] ins,
                                  input logic [31:0] pc, input logic [31:0] tv);
    exp_t a;
    a = '0;
    a.instr = ins; a.pc = pc; a.tval = tv;
    a.alu_op = c.alu_op; a.alu_from_imm = c.alu_from_imm; a.reg_write = c.reg_write;
    a.reg_data = c.reg_data; a.mem_type = c.mem_type; a.csr_op = c.csr_op;
    a.csr_source = c.csr_source; a.trap_req = c.trap_req; a.exc_cause = c.exc_cause;
    a.exc_ret = c.exc_ret; a.is_wfi = c.is_wfi; a.is_m = c.is_m;
    return a;
  endfunction

  function automatic exp_t base(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    e = '0;
    e.instr = ins;
    e.pc    = pc;
    return e;
  endfunction

  function automatic exp_t ex_alu(input logic [31:0] ins, input logic [31:0] pc,
                                  input alu_op_t op, input logic imm);
    exp_t e;
    e = base(ins, pc);
    e.alu_op = op;
    e.alu_from_imm = imm;
    e.reg_write = 1'b1;
    return e;
  endfunction

  function automatic exp_t ex_trap(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] cause);
    exp_t e;
    e = base(ins, pc);
    e.trap_req  = 1'b1;
    e.exc_cause = cause;
    if (cause == 32'd2) e.tval = ins;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one instruction until accepted; expectation is queued at the accepting edge.
  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input exp_t e0, input exp_t e1);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    n_tests++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL send_timeout: instr %h not accepted after %0d cycles", ins, n);
    end else begin
      q0.push_back(e0);
      q1.push_back(e1);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Hand off a trap/return entry, confirm issue is held, then release with flush.
  task automatic hold_test(input string name, input logic [31:0] ins, input exp_t e, input int cycles);
    send(ins, 32'h400, e, e);
    idle();
    repeat (cycles) begin
      @(negedge clk); #1;
      check({name, "_hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    @(negedge clk) flush = 1'b1;
    @(negedge clk) flush = 1'b0;
    #1 check({name, "_release_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  // Scoreboard monitor for the instance without M.
  always begin : mon0
    exp_t e, a;
    @(negedge clk); #1;
    if (dec_valid && dec_ready) begin
      n_tests++;
      a = act_of(dec_ctrl, dec_instr, dec_pc, dec_tval);
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL dut_entry: unexpected entry %h", a);
      end else begin
        e = q0.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL dut_entry: got %h expected %h", a, e);
        end
      end
    end
  end

  // Scoreboard monitor for the instance with M.
  always begin : mon1
    exp_t e, a;
    @(negedge clk); #1;
    if (m_dec_valid && dec_ready) begin
      n_tests++;
      a = act_of(m_dec_ctrl, m_dec_instr, m_dec_pc, m_dec_tval);
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL dut_m_entry: unexpected entry %h", a);
      end else begin
        e = q1.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL dut_m_entry: got %h expected %h", a, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e, em;
    rst_n = 1'b0; in_valid = 1'b0; dec_ready = 1'b0; flush = 1'b0; irq_pending = 1'b0;
    in_instr = '0; in_pc = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_dec_valid", 64'(dec_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_dec_ctrl", 64'(dec_ctrl), 64'd0);
    check("rst_dec_count", 64'(dec_count), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("rst_release_in_ready_0", 64'(in_ready), 64'd0);
    @(negedge clk); #1 check("rst_release_in_ready_1", 64'(in_ready), 64'd1);

    // Single addi, one-cycle latency
    @(negedge clk) dec_ready = 1'b1;
    e = ex_alu(32'h00500093, 32'h100, ALU_ADD, 1'b1);
    send(32'h00500093, 32'h100, e, e);
    idle();
    #1 check("addi_latency_dec_valid", 64'(dec_valid), 64'd1);
    repeat (2) @(negedge clk);
    #1 check("addi_count", 64'(dec_count), 64'd1);

    // Back-pressure: two entries fill the buffer, third waits
    @(negedge clk) dec_ready = 1'b0;
    e = ex_alu(32'h00500093, 32'h200, ALU_ADD, 1'b1);
    send(32'h00500093, 32'h200, e, e);
    e = ex_alu(32'h00100113, 32'h204, ALU_ADD, 1'b1);
    send(32'h00100113, 32'h204, e, e);
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h208;
    #1 check("full_in_ready", 64'(in_ready), 64'd0);
    repeat (3) @(negedge clk);
    #1 check("full_in_ready_stall", 64'(in_ready), 64'd0);
    check("full_head_order", 64'(dec_instr), 64'h00500093);
    @(negedge clk) dec_ready = 1'b1;
    e = ex_alu(32'h002081B3, 32'h208, ALU_ADD, 1'b0);
    send(32'h002081B3, 32'h208, e, e);
    idle();
    repeat (3) @(negedge clk);
    #1 check("stream_count", 64'(dec_count), 64'd4);

    // Load, jump-and-link, immediate CSR write back to back
    e = ex_alu(32'h0080A283, 32'h300, ALU_ADD, 1'b1);
    e.reg_data = WB_MEM; e.mem_type = MEM_LW;
    send(32'h0080A283, 32'h300, e, e);
    e = ex_alu(32'h008000EF, 32'h304, ALU_ADD, 1'b1);
    e.reg_data = WB_PC4;
    send(32'h008000EF, 32'h304, e, e);
    e = ex_alu(32'h3002D073, 32'h308, ALU_ADD, 1'b0);
    e.reg_data = WB_CSR; e.csr_op = CSR_RW; e.csr_source = 1'b1;
    send(32'h3002D073, 32'h308, e, e);
    idle();
    repeat (3) @(negedge clk);
    #1 check("misc_count", 64'(dec_count), 64'd7);

    // mul: illegal without M, MUL with M
    e  = ex_trap(32'h022081B3, 32'h310, 32'd2);
    em = ex_alu(32'h022081B3, 32'h310, ALU_MUL, 1'b0);
    em.is_m = 1'b1;
    send(32'h022081B3, 32'h310, e, em);
    idle();
    repeat (2) @(negedge clk);
    #1;
    check("mul_hold_in_ready", 64'(in_ready), 64'd0);
    check("mul_m_in_ready", 64'(m_in_ready), 64'd1);
    check("mul_hold_dec_valid", 64'(dec_valid), 64'd0);
    @(negedge clk) flush = 1'b1;
    @(negedge clk) flush = 1'b0;
    #1 check("mul_release_in_ready", 64'(in_ready), 64'd1);
    check("mul_count", 64'(dec_count), 64'd8);

    // Trap and return entries hold issue until flush
    e = ex_trap(32'h00000073, 32'h400, 32'd11);
    hold_test("ecall", 32'h00000073, e, 10);
    e = ex_trap(32'h00100073, 32'h400, 32'd3);
    hold_test("ebreak", 32'h00100073, e, 3);
    e = base(32'h30200073, 32'h400);
    e.exc_ret = 1'b1;
    hold_test("mret", 32'h30200073, e, 3);
    e = ex_trap(32'h02009093, 32'h400, 32'd2);
    hold_test("slli_bad", 32'h02009093, e, 2);

    // WFI parks the following entry until an interrupt is pending
    e = base(32'h10500073, 32'h500);
    e.is_wfi = 1'b1;
    send(32'h10500073, 32'h500, e, e);
    e = ex_alu(32'h00700213, 32'h504, ALU_ADD, 1'b1);
    send(32'h00700213, 32'h504, e, e);
    idle();
    repeat (2) @(negedge clk);
    #1;
    check("wfi_dec_valid", 64'(dec_valid), 64'd0);
    check("wfi_in_ready", 64'(in_ready), 64'd0);
    check("wfi_buffered_instr", 64'(dec_instr), 64'h00700213);
    @(negedge clk) irq_pending = 1'b1;
    @(negedge clk) irq_pending = 1'b0;
    #1 check("wfi_wake_dec_valid", 64'(dec_valid), 64'd1);

    // Flush drops a same-edge accept but still counts a same-edge hand-off
    e = ex_alu(32'h00300293, 32'h600, ALU_ADD, 1'b1);
    send(32'h00300293, 32'h600, e, e);
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h00900313; in_pc = 32'h604; flush = 1'b1;
    #1 check("flush_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("flush_dropped_dec_valid", 64'(dec_valid), 64'd0);
    check("flush_count", 64'(dec_count), 64'd15);
    check("scoreboard_drained", 64'(q0.size()), 64'd0);
    check("scoreboard_m_drained", 64'(q1.size()), 64'd0);

    // Reset with both entries occupied
    @(negedge clk) dec_ready = 1'b0;
    e = ex_alu(32'h00500093, 32'h700, ALU_ADD, 1'b1);
    send(32'h00500093, 32'h700, e, e);
    e = ex_alu(32'h00100113, 32'h704, ALU_ADD, 1'b1);
    send(32'h00100113, 32'h704, e, e);
    idle();
    #1;
    check("prerst_full_in_ready", 64'(in_ready), 64'd0);
    check("prerst_dec_valid", 64'(dec_valid), 64'd1);
    q0.delete();
    q1.delete();
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("midrst_dec_valid", 64'(dec_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_dec_ctrl", 64'(dec_ctrl), 64'd0);
    check("midrst_dec_pc", 64'(dec_pc), 64'd0);
    check("midrst_dec_instr", 64'(dec_instr), 64'd0);
    check("midrst_dec_tval", 64'(dec_tval), 64'd0);
    check("midrst_dec_count", 64'(dec_count), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("midrst_release_in_ready_0", 64'(in_ready), 64'd0);
    @(negedge clk);
    #1;
    check("midrst_release_in_ready_1", 64'(in_ready), 64'd1);
    check("midrst_release_dec_valid", 64'(dec_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
